// File: rtl/exmem_stage.sv
// ---------------------------------------------------------------------------
// exmem_stage
//   EX/MEM pipeline register with a blocking data-memory handshake.
//   An instruction is captured whenever the stage is not stalled. Loads and
//   stores hold the stage in WAIT (stalling upstream) until the memory
//   returns mem_ack. The instruction is then handed to MEM/WB for exactly
//   one cycle.
//
// Ports
//   clk                  pipeline clock, rising edge
//   reset                asynchronous active-low reset
//   valid_in             EX presents a real instruction
//   flush                squash the instruction being captured
//   control_signals_in   EX control word ([9] rf_en, [6] mem_read,
//                        [5] mem_write, [2] hi_en, [1] lo_en)
//   alu_result_in        ALU result / memory address
//   store_data_in        store data (rt)
//   dest_reg_in          writeback register number
//   mem_ack              one-cycle memory completion strobe
//   mem_rdata            read data, valid with mem_ack
//   control_signals_out  control word to MEM/WB, zero when nothing presented
//   alu_result_out       registered ALU result
//   dest_reg_out         registered destination register
//   mem_result_out       captured load data
//   valid_out            instruction presented to MEM/WB this cycle
//   mem_req / mem_we     memory request / request is a write
//   mem_addr / mem_wdata request address / store data
//   stall_out            upstream hold while a memory access is pending
// ---------------------------------------------------------------------------
module exmem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        flush,
    input  logic [21:0] control_signals_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  dest_reg_in,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [21:0] control_signals_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  dest_reg_out,
    output logic [31:0] mem_result_out,
    output logic        valid_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        stall_out
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]  state;
    logic [21:0] ctrl_p0;
    logic [31:0] alu_p0;
    logic [31:0] wdata_p0;
    logic [4:0]  dest_p0;
    logic        vld_p0;
    logic [31:0] mem_result_p0;

    // ---- capture stage: EX -> internal registers, memory handshake ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ctrl_p0       <= '0;
            alu_p0        <= '0;
            wdata_p0      <= '0;
            dest_p0       <= '0;
            vld_p0        <= 1'b0;
            mem_result_p0 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in && !flush) begin
                        ctrl_p0  <= control_signals_in;
                        alu_p0   <= alu_result_in;
                        wdata_p0 <= store_data_in;
                        dest_p0  <= dest_reg_in;
                        vld_p0   <= 1'b1;
                        if (control_signals_in[6] || control_signals_in[5])
                            state <= WAIT;
                    end else begin
                        // Bubble: squashed or empty slot leaves nothing behind.
                        ctrl_p0  <= '0;
                        alu_p0   <= '0;
                        wdata_p0 <= '0;
                        dest_p0  <= '0;
                        vld_p0   <= 1'b0;
                    end
                end
                WAIT: begin
                    // Registers hold; the issued access is committed, so
                    // valid_in/flush are not looked at here. No timeout.
                    if (mem_ack) begin
                        state <= IDLE;
                        // Write wins when both read and write are flagged.
                        if (ctrl_p0[6] && !ctrl_p0[5])
                            mem_result_p0 <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- output stage: presentation to MEM/WB and memory port ----
    always_comb begin
        stall_out           = (state == WAIT);
        mem_req             = (state == WAIT);
        mem_we              = mem_req & ctrl_p0[5];
        valid_out           = (state == IDLE) & vld_p0;
        control_signals_out = valid_out ? ctrl_p0 : 22'b0;
        alu_result_out      = alu_p0;
        dest_reg_out        = dest_p0;
        mem_addr            = alu_p0;
        mem_wdata           = wdata_p0;
        mem_result_out      = mem_result_p0;
    end

endmodule

// File: tb/tb_exmem_stage.sv
module tb_exmem_stage;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        flush;
    logic [21:0] control_signals_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [4:0]  dest_reg_in;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [21:0] control_signals_out;
    logic [31:0] alu_result_out;
    logic [4:0]  dest_reg_out;
    logic [31:0] mem_result_out;
    logic        valid_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall_out;

    int vectors;
    int errors;

    exmem_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .valid_in            (valid_in),
        .flush               (flush),
        .control_signals_in  (control_signals_in),
        .alu_result_in       (alu_result_in),
        .store_data_in       (store_data_in),
        .dest_reg_in         (dest_reg_in),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .control_signals_out (control_signals_out),
        .alu_result_out      (alu_result_out),
        .dest_reg_out        (dest_reg_out),
        .mem_result_out      (mem_result_out),
        .valid_out           (valid_out),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .stall_out           (stall_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [21:0] c,
                         input logic [31:0] a, input logic [31:0] s,
                         input logic [4:0] d);
        valid_in           = v;
        flush              = f;
        control_signals_in = c;
        alu_result_in      = a;
        store_data_in      = s;
        dest_reg_in        = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 1'b0, 22'h000240, 32'h99, 32'h77, 5'd9);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF0000;
        tick();
        vectors++;
        if ({valid_out, mem_req, mem_we, stall_out} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {valid_out, mem_req, mem_we, stall_out});
        end
        vectors++;
        if (control_signals_out !== 22'h0 || alu_result_out !== 32'h0 || dest_reg_out !== 5'd0) begin
            errors++;
            $display("FAIL reset_regs got ctrl=%h alu=%h dest=%0d want zeros",
                     control_signals_out, alu_result_out, dest_reg_out);
        end
        vectors++;
        if (mem_result_out !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_memres got res=%h wdata=%h want 0", mem_result_out, mem_wdata);
        end
        drive(1'b0, 1'b0, 22'h0, 32'h0, 32'h0, 5'd0);
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        reset = 1'b1;
    endtask

    task automatic test_add();
        drive(1'b1, 1'b0, 22'h000200, 32'h1234, 32'h0, 5'd5);
        tick();
        vectors++;
        if (control_signals_out !== 22'h000200 || valid_out !== 1'b1 || dest_reg_out !== 5'd5) begin
            errors++;
            $display("FAIL add_present got ctrl=%h v=%b dest=%0d want 000200 1 5",
                     control_signals_out, valid_out, dest_reg_out);
        end
        vectors++;
        if (mem_req !== 1'b0 || stall_out !== 1'b0 || alu_result_out !== 32'h1234) begin
            errors++;
            $display("FAIL add_nomem got req=%b stall=%b alu=%h want 0 0 1234",
                     mem_req, stall_out, alu_result_out);
        end
        drive(1'b0, 1'b0, 22'h0, 32'h0, 32'h0, 5'd0);
        tick();
        vectors++;
        if (valid_out !== 1'b0 || control_signals_out !== 22'h0) begin
            errors++;
            $display("FAIL add_once got v=%b ctrl=%h want 0 0", valid_out, control_signals_out);
        end
    endtask

    task automatic test_load();
        drive(1'b1, 1'b0, 22'h000240, 32'h40, 32'h0, 5'd8);
        tick();
        drive(1'b0, 1'b0, 22'h0, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || stall_out !== 1'b1 ||
                mem_addr !== 32'h40 || control_signals_out !== 22'h0 || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL lw_wait%0d got req=%b we=%b stall=%b addr=%h ctrl=%h v=%b want 1 0 1 40 0 0",
                         i, mem_req, mem_we, stall_out, mem_addr, control_signals_out, valid_out);
            end
            if (i == 3) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hDEADBEEF;
            end
            tick();
        end
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        vectors++;
        if (valid_out !== 1'b1 || mem_result_out !== 32'hDEADBEEF || control_signals_out !== 22'h000240 ||
            dest_reg_out !== 5'd8 || stall_out !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL lw_present got v=%b res=%h ctrl=%h dest=%0d stall=%b req=%b want 1 deadbeef 000240 8 0 0",
                     valid_out, mem_result_out, control_signals_out, dest_reg_out, stall_out, mem_req);
        end
        // A stray ack while idle must neither stall nor overwrite load data.
        mem_ack = 1'b1;
        mem_rdata = 32'h11111111;
        tick();
        mem_ack = 1'b0;
        vectors++;
        if (valid_out !== 1'b0 || stall_out !== 1'b0 || mem_result_out !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_idle_ack got v=%b stall=%b res=%h want 0 0 deadbeef",
                     valid_out, stall_out, mem_result_out);
        end
    endtask

    task automatic test_store();
        drive(1'b1, 1'b0, 22'h000020, 32'h80, 32'hCAFEF00D, 5'd0);
        tick();
        drive(1'b0, 1'b0, 22'h0, 32'h0, 32'h0, 5'd0);
        vectors++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hCAFEF00D || mem_addr !== 32'h80) begin
            errors++;
            $display("FAIL sw_wait got req=%b we=%b wdata=%h addr=%h want 1 1 cafef00d 80",
                     mem_req, mem_we, mem_wdata, mem_addr);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'h55555555;
        tick();
        mem_ack = 1'b0;
        vectors++;
        if (valid_out !== 1'b1 || control_signals_out !== 22'h000020 || mem_we !== 1'b0 ||
            mem_result_out !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_present got v=%b ctrl=%h we=%b res=%h want 1 000020 0 deadbeef",
                     valid_out, control_signals_out, mem_we, mem_result_out);
        end
        tick();
        vectors++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL sw_once got v=%b want 0", valid_out);
        end
        // Read and write both flagged: write wins.
        drive(1'b1, 1'b0, 22'h000060, 32'h84, 32'h0F0F0F0F, 5'd0);
        tick();
        drive(1'b0, 1'b0, 22'h0, 32'h0, 32'h0, 5'd0);
        vectors++;
        if (mem_we !== 1'b1 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rw_prio_we got we=%b req=%b want 1 1", mem_we, mem_req);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'h77777777;
        tick();
        mem_ack = 1'b0;
        vectors++;
        if (valid_out !== 1'b1 || mem_result_out !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rw_prio_res got v=%b res=%h want 1 deadbeef", valid_out, mem_result_out);
        end
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 22'h000200, 32'h2222, 32'h0, 5'd7);
        tick();
        vectors++;
        if (valid_out !== 1'b0 || control_signals_out !== 22'h0 || alu_result_out !== 32'h0 ||
            dest_reg_out !== 5'd0) begin
            errors++;
            $display("FAIL flush_bubble got v=%b ctrl=%h alu=%h dest=%0d want 0 0 0 0",
                     valid_out, control_signals_out, alu_result_out, dest_reg_out);
        end
        drive(1'b1, 1'b0, 22'h000240, 32'h44, 32'h0, 5'd4);
        tick();
        // Flush and a new instruction during WAIT are both ignored.
        drive(1'b1, 1'b1, 22'h000200, 32'h3333, 32'h0, 5'd6);
        tick();
        vectors++;
        if (stall_out !== 1'b1 || mem_addr !== 32'h44 || dest_reg_out !== 5'd4) begin
            errors++;
            $display("FAIL flush_wait got stall=%b addr=%h dest=%0d want 1 44 4",
                     stall_out, mem_addr, dest_reg_out);
        end
        drive(1'b0, 1'b0, 22'h0, 32'h0, 32'h0, 5'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'h0BADF00D;
        tick();
        mem_ack = 1'b0;
        vectors++;
        if (valid_out !== 1'b1 || mem_result_out !== 32'h0BADF00D || alu_result_out !== 32'h44) begin
            errors++;
            $display("FAIL flush_lw_done got v=%b res=%h alu=%h want 1 0badf00d 44",
                     valid_out, mem_result_out, alu_result_out);
        end
        tick();
    endtask

    task automatic test_reset_wait();
        drive(1'b1, 1'b0, 22'h000240, 32'h48, 32'h0, 5'd3);
        tick();
        drive(1'b0, 1'b0, 22'h0, 32'h0, 32'h0, 5'd0);
        vectors++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstw_pre got req=%b want 1", mem_req);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || stall_out !== 1'b0 || mem_result_out !== 32'h0) begin
            errors++;
            $display("FAIL rstw_async got req=%b stall=%b res=%h want 0 0 0",
                     mem_req, stall_out, mem_result_out);
        end
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        vectors++;
        if (stall_out !== 1'b0 || mem_req !== 1'b0 || mem_result_out !== 32'h0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL rstw_late_ack got stall=%b req=%b res=%h v=%b want 0 0 0 0",
                     stall_out, mem_req, mem_result_out, valid_out);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 22'h000200, 32'h10, 32'h0, 5'd1);
        tick();
        vectors++;
        if (valid_out !== 1'b1 || dest_reg_out !== 5'd1) begin
            errors++;
            $display("FAIL b2b_add1 got v=%b dest=%0d want 1 1", valid_out, dest_reg_out);
        end
        drive(1'b1, 1'b0, 22'h000240, 32'h50, 32'h0, 5'd2);
        tick();
        drive(1'b1, 1'b0, 22'h000200, 32'h20, 32'h0, 5'd3);
        vectors++;
        if (valid_out !== 1'b0 || stall_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wait1 got v=%b stall=%b want 0 1", valid_out, stall_out);
        end
        tick();
        vectors++;
        if (valid_out !== 1'b0 || stall_out !== 1'b1 || dest_reg_out !== 5'd2) begin
            errors++;
            $display("FAIL b2b_wait2 got v=%b stall=%b dest=%0d want 0 1 2",
                     valid_out, stall_out, dest_reg_out);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'hA5A5A5A5;
        tick();
        mem_ack = 1'b0;
        vectors++;
        if (valid_out !== 1'b1 || dest_reg_out !== 5'd2 || mem_result_out !== 32'hA5A5A5A5 ||
            control_signals_out !== 22'h000240) begin
            errors++;
            $display("FAIL b2b_lw got v=%b dest=%0d res=%h ctrl=%h want 1 2 a5a5a5a5 000240",
                     valid_out, dest_reg_out, mem_result_out, control_signals_out);
        end
        tick();
        drive(1'b0, 1'b0, 22'h0, 32'h0, 32'h0, 5'd0);
        vectors++;
        if (valid_out !== 1'b1 || dest_reg_out !== 5'd3 || alu_result_out !== 32'h20) begin
            errors++;
            $display("FAIL b2b_add2 got v=%b dest=%0d alu=%h want 1 3 20",
                     valid_out, dest_reg_out, alu_result_out);
        end
        tick();
        vectors++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got v=%b want 0", valid_out);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        test_reset();
        test_add();
        test_load();
        test_store();
        test_flush();
        test_reset_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/exmem_stage.md
EXMEM_STAGE -- requirements
Module: exmem_stage

Interface
REQ-001 clk  input  1  single pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low; low forces reset state immediately, independent of clk.
REQ-003 valid_in  input  1  EX stage presents a real instruction this cycle.
REQ-004 flush  input  1  squash the instruction being captured this edge.
REQ-005 control_signals_in  input  22  EX control word; [9] rf_enable, [6] mem_read, [5] mem_write, [2] hi_enable, [1] lo_enable.
REQ-006 alu_result_in  input  32  ALU result; also the memory address.
REQ-007 store_data_in  input  32  rt value for stores.
REQ-008 dest_reg_in  input  5  writeback register number.
REQ-009 mem_ack  input  1  data memory completion strobe, one cycle.
REQ-010 mem_rdata  input  32  read data, valid when mem_ack=1.
REQ-011 control_signals_out  output  22  control word to the MEM/WB stage; zero when no instruction is presented.
REQ-012 alu_result_out  output  32  registered ALU result.
REQ-013 dest_reg_out  output  5  registered destination register.
REQ-014 mem_result_out  output  32  captured load data.
REQ-015 valid_out  output  1  an instruction is presented to MEM/WB this cycle.
REQ-016 mem_req  output  1  memory request active.
REQ-017 mem_we  output  1  request is a write.
REQ-018 mem_addr  output  32  request address, equal to alu_result_out.
REQ-019 mem_wdata  output  32  registered store data.
REQ-020 stall_out  output  1  stall to IF/ID/EX; upstream holds its outputs while high.

Function
REQ-021 The block SHALL implement a two-state FSM: IDLE and WAIT.
REQ-022 capture condition: stall_out=0 at a rising edge.
REQ-023 On capture with valid_in=1 and flush=0, the block SHALL load ctrl, alu_result, store_data and dest_reg into internal registers and set the internal valid bit.
REQ-024 On capture with valid_in=0 or flush=1, the block SHALL load a bubble: all registers zero, valid bit 0.
REQ-025 IDLE->WAIT on a capture that loads an instruction with ctrl[6]=1 or ctrl[5]=1; otherwise the FSM stays in IDLE.
REQ-026 WAIT->IDLE on a rising edge with mem_ack=1; otherwise the FSM stays in WAIT with no timeout.
REQ-027 stall_out SHALL be combinational and equal to (state==WAIT).
REQ-028 In WAIT, the internal registers SHALL hold; valid_in and flush SHALL be ignored, because an issued access is committed.
REQ-029 mem_req SHALL be (state==WAIT); mem_we = ctrl[5] while mem_req=1, else 0; mem_addr and mem_wdata come from the internal registers.
REQ-030 If ctrl[5] and ctrl[6] are both set, the write SHALL take priority: mem_we=1 and mem_result_out is not updated.
REQ-031 On the WAIT->IDLE edge of a read (ctrl[6]=1, ctrl[5]=0), mem_result_out SHALL load mem_rdata; otherwise mem_result_out holds.
REQ-032 valid_out SHALL be (state==IDLE) and valid bit; control_signals_out = valid_out ? ctrl : 22'b0.
REQ-033 Each instruction SHALL be presented to MEM/WB with valid_out=1 for exactly one cycle.
REQ-034 Latency: a non-memory instruction is presented the cycle after capture; a memory instruction is presented the cycle after its mem_ack edge.
REQ-035 mem_ack received in IDLE SHALL be ignored.
REQ-036 The internal registers SHALL NOT be loaded on the mem_ack edge; the next capture is the following edge.

Reset
REQ-037 While reset=0, all of the following SHALL hold immediately: state=IDLE; all internal registers and mem_result_out are zero; valid_out, mem_req, mem_we and stall_out are 0.
REQ-038 Reset asserted during WAIT SHALL abandon the access: mem_req drops asynchronously, and a late mem_ack after release is ignored.
REQ-039 The first capture SHALL occur on the first rising edge with reset=1.

Verification
REQ-040 Reset release, then ADD ctrl=0x000200, alu_result=0x1234, dest=5 -> next cycle control_signals_out=0x000200, valid_out=1, dest_reg_out=5, mem_req=0, stall_out=0.
REQ-041 LW ctrl[6]=1, alu_result=0x40, with mem_ack held for 3 cycles and then pulsed with mem_rdata=0xDEADBEEF -> mem_req=1, mem_we=0, mem_addr=0x40 and stall_out=1 for 4 cycles, control_signals_out=0 during that time; next cycle valid_out=1 and mem_result_out=0xDEADBEEF.
REQ-042 SW ctrl[5]=1, store_data=0xCAFEF00D, mem_ack on the first WAIT cycle -> mem_we=1, mem_wdata=0xCAFEF00D for 1 cycle, then presented for 1 cycle with mem_result_out unchanged.
REQ-043 flush=1 with a valid ADD at a capture edge -> valid_out=0 and control_signals_out=0; flush=1 during WAIT -> no effect, and the load completes.
REQ-044 reset=0 mid-WAIT, then mem_ack=1 after release -> mem_req drops immediately, the state stays IDLE, and mem_result_out=0.
REQ-045 Back-to-back ADD, LW, ADD with mem_ack on the second WAIT cycle -> each instruction has exactly one valid_out=1 cycle, in order; the second ADD is captured on the edge after the ack edge.
